uart_note_sequencer: RTL and testbench
======================================

// Module: uart_note_sequencer
// PURPOSE
//  Upstream feeder for the beeper music player. Parses note frames from the UART receiver byte stream
//  and buffers them in a FIFO. Issues each (note, time) pair to the player using the player's en/music_busy
//  handshake. Lets a host queue a tune while the player is still sounding the current note.
// PARAMETERS
//  DEPTH        8       FIFO entries (power of 2, >=2); each entry is {note[7:0], time[7:0]}
//  CLK_PER_MS   12000   clk_in cycles per millisecond (12 MHz board clock)
//  TIMEOUT_MS   20      maximum gap between bytes inside a frame before the frame is abandoned
// PORTS
//  clk_in       in   1   system clock
//  rst_n_in     in   1   asynchronous reset, active-low
//  rx_data      in   8   received UART byte
//  rx_valid     in   1   one-cycle strobe: rx_data valid
//  music_busy   in   1   player busy flag
//  en           out  1   play request to the player
//  music_note   out  8   tone code to the player; stable while en=1 or music_busy=1
//  music_time   out  8   note duration in ms to the player; stable as music_note
//  fifo_level   out  $clog2(DEPTH)+1  current number of queued entries
//  frame_err    out  1   one-cycle pulse: bad checksum or inter-byte timeout
//  overflow     out  1   one-cycle pulse: valid frame dropped because the FIFO was full
// BEHAVIOUR
//  Reset values: en=0, music_note=0, music_time=0, fifo_level=0, frame_err=0, overflow=0; FIFO empty; both FSMs idle.
//  Frame format: SYNC(0xA5), NOTE, TIME[, SUM]. SUM = NOTE ^ TIME ^ 0x5A.
//  Parser FSM (advances only on rx_valid): P_SYNC -> P_NOTE -> P_TIME [-> P_SUM] -> P_SYNC.
//   - In P_SYNC, any byte other than 0xA5 is discarded silently.
//   - Inter-byte timer: counts ms while the parser is not in P_SYNC and resets on every rx_valid.
//     At TIMEOUT_MS it pulses frame_err and returns the parser to P_SYNC.
//   - Frame completes: a checksum mismatch pulses frame_err and drops the frame.
//     Otherwise, NOTE==0xFF is a FLUSH command: the FIFO empties on the next cycle; an in-flight note is not aborted.
//     Otherwise, push {NOTE,TIME}. If the FIFO is full, drop the frame and pulse overflow.
//  Push latency: fifo_level increments the cycle after the final frame byte's rx_valid.
//  Dispatcher FSM:
//   D_IDLE:  when the FIFO is non-empty and music_busy=0: pop the head, load music_note/music_time, and set en=1 -> D_REQ.
//   D_REQ:   hold en=1 until music_busy=1 is sampled, then en=0 -> D_PLAY.
//   D_PLAY:  wait for music_busy=0 -> D_IDLE. There is a minimum of 1 idle cycle between notes.
//  Simultaneous push and pop on the same cycle are both honoured; level is unchanged (also when full).
//  A flush coinciding with a pop: flush wins and the level goes to 0; the popped entry is still dispatched.
//  Pointers wrap modulo DEPTH. The level saturates at DEPTH by construction; there is no write when full.
//  Asynchronous reset mid-frame or mid-note returns everything to reset values immediately; a partial frame is lost.
// CONFIGURATION
//  NOTE_SEQ_CHECKSUM_EN defined: 4-byte frames, with the SUM byte checked as above.
//  NOTE_SEQ_CHECKSUM_EN undefined: 3-byte frames. P_SUM is removed and frame_err is raised only on timeout.
// STRUCTURE
//  Shared package note_seq_pkg: SYNC_BYTE=8'hA5, FLUSH_NOTE=8'hFF, SUM_SALT=8'h5A, plus the parser and dispatcher state encodings.
//  Sub-module note_fifo: synchronous FIFO, 16-bit x DEPTH, with push, pop, flush, full, empty and level outputs.
//  The top level holds the parser FSM, the ms prescaler/timeout counter and the dispatcher FSM.
// TESTING
//  Send A5 3C 10 (+SUM 76 if enabled), player model idle:
//   en rises, music_note=0x3C, music_time=0x10; en falls the cycle after busy=1.
//  Send 9 valid frames with busy held at 1 and DEPTH=8: fifo_level=8 and exactly one overflow pulse on the 9th frame.
//  Send A5 3C 10 00 with checksum enabled: frame_err pulse, fifo_level stays 0, en stays 0.
//  Send A5 3C, then idle for 21 ms: frame_err pulse at 20 ms. A following A5 11 22 (+SUM) is accepted.
//  Queue 3 notes, then send A5 FF xx (+SUM) while note 1 plays: fifo_level=0, and only note 1 completes.
//  Assert rst_n_in low during D_REQ: en=0 and fifo_level=0 immediately; after release, no en without a new frame.

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared constants, state encodings and the FIFO entry layout for the
// UART note sequencer.
package note_seq_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] FLUSH_NOTE = 8'hFF;
  localparam logic [7:0] SUM_SALT   = 8'h5A;

  // Parser states
  localparam logic [1:0] P_SYNC = 2'd0;
  localparam logic [1:0] P_NOTE = 2'd1;
  localparam logic [1:0] P_TIME = 2'd2;
  localparam logic [1:0] P_SUM  = 2'd3;

  // Dispatcher states
  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_REQ  = 2'd1;
  localparam logic [1:0] D_PLAY = 2'd2;

  typedef struct packed {
    logic [7:0] note;
    logic [7:0] dur;
  } note_entry_t;

  function automatic logic [7:0] frame_sum(input logic [7:0] note, input logic [7:0] dur);
    return note ^ dur ^ SUM_SALT;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO of queued {note, duration} entries. Flush empties the
// FIFO on the next cycle and wins over any simultaneous push or pop; a push
// while full is only accepted when a pop frees the slot in the same cycle.
module note_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointer and level bookkeeping; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end
  end

  // Storage write; contents need no reset because level gates every read
  always_comb begin
    mem_d = mem_q;
    if (do_push && !flush) mem_d[wr_ptr_q] = wr_data;
  end

  // Storage register
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  // Control registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_note_sequencer.sv
// UART note sequencer: parses SYNC/NOTE/TIME[/SUM] frames from the UART
// byte stream, queues notes in a FIFO and hands them to the beeper player
// over its en/music_busy handshake.
// Define NOTE_SEQ_CHECKSUM_EN for 4-byte frames with a checked SUM byte;
// without it frames are 3 bytes and frame_err only reports timeouts.
module uart_note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int CLK_PER_MS = 12000,
  parameter int TIMEOUT_MS = 20
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   music_busy,
  output logic                   en,
  output logic [7:0]             music_note,
  output logic [7:0]             music_time,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int MW = $clog2(TIMEOUT_MS + 1);

  logic [1:0]    p_state_q, p_state_d;
  logic [7:0]    note_q, note_d;
`ifdef NOTE_SEQ_CHECKSUM_EN
  logic [7:0]    time_q, time_d;
`endif
  logic [PW-1:0] presc_q, presc_d;
  logic [MW-1:0] ms_q, ms_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic          timeout;
  logic          frame_done;
  logic [7:0]    frame_time;
  logic          push_req, flush_req;

  logic [1:0]    d_state_q, d_state_d;
  logic          en_q, en_d;
  logic [7:0]    music_note_q, music_note_d;
  logic [7:0]    music_time_q, music_time_d;
  logic          pop_req;

  logic          fifo_full, fifo_empty;
  note_entry_t   head_entry;
  note_entry_t   push_entry;

  assign push_entry = '{note: note_q, dur: frame_time};

  note_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (push_req),
    .pop      (pop_req),
    .flush    (flush_req),
    .wr_data  (push_entry),
    .rd_data  (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Inter-byte timer: ms prescaler plus ms count, cleared by every byte and held idle while hunting for sync
  always_comb begin
    presc_d = presc_q;
    ms_d    = ms_q;
    if (rx_valid || p_state_q == P_SYNC) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (presc_q == PW'(CLK_PER_MS - 1)) begin
      presc_d = '0;
      ms_d    = ms_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  assign timeout = (p_state_q != P_SYNC) && !rx_valid &&
                   (presc_q == PW'(CLK_PER_MS - 1)) && (ms_q == MW'(TIMEOUT_MS - 1));

  // Frame parser: push/flush are issued on the final byte so the FIFO updates on the next edge
  always_comb begin
    p_state_d   = p_state_q;
    note_d      = note_q;
`ifdef NOTE_SEQ_CHECKSUM_EN
    time_d      = time_q;
`endif
    frame_err_d = 1'b0;
    frame_done  = 1'b0;
    frame_time  = rx_data;
    if (rx_valid) begin
      case (p_state_q)
        P_SYNC: if (rx_data == SYNC_BYTE) p_state_d = P_NOTE;
        P_NOTE: begin
          note_d    = rx_data;
          p_state_d = P_TIME;
        end
`ifdef NOTE_SEQ_CHECKSUM_EN
        P_TIME: begin
          time_d    = rx_data;
          p_state_d = P_SUM;
        end
        P_SUM: begin
          p_state_d  = P_SYNC;
          frame_time = time_q;
          if (rx_data == frame_sum(note_q, time_q)) frame_done  = 1'b1;
          else                                      frame_err_d = 1'b1;
        end
`else
        P_TIME: begin
          p_state_d  = P_SYNC;
          frame_done = 1'b1;
        end
`endif
        default: p_state_d = P_SYNC;
      endcase
    end else if (timeout) begin
      frame_err_d = 1'b1;
      p_state_d   = P_SYNC;
    end
  end

  assign flush_req  = frame_done && (note_q == FLUSH_NOTE);
  assign push_req   = frame_done && (note_q != FLUSH_NOTE);
  assign overflow_d = push_req && fifo_full && !pop_req;

  // Dispatcher: pop the head when the player is free, hold en until busy is seen, then wait for the note to end
  always_comb begin
    d_state_d    = d_state_q;
    en_d         = en_q;
    music_note_d = music_note_q;
    music_time_d = music_time_q;
    pop_req      = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        if (!fifo_empty && !music_busy) begin
          pop_req      = 1'b1;
          music_note_d = head_entry.note;
          music_time_d = head_entry.dur;
          en_d         = 1'b1;
          d_state_d    = D_REQ;
        end
      end
      D_REQ: begin
        if (music_busy) begin
          en_d      = 1'b0;
          d_state_d = D_PLAY;
        end
      end
      D_PLAY: if (!music_busy) d_state_d = D_IDLE;
      default: begin
        en_d      = 1'b0;
        d_state_d = D_IDLE;
      end
    endcase
  end

  // State registers for parser, timer and dispatcher
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      p_state_q    <= P_SYNC;
      note_q       <= '0;
`ifdef NOTE_SEQ_CHECKSUM_EN
      time_q       <= '0;
`endif
      presc_q      <= '0;
      ms_q         <= '0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      d_state_q    <= D_IDLE;
      en_q         <= 1'b0;
      music_note_q <= '0;
      music_time_q <= '0;
    end else begin
      p_state_q    <= p_state_d;
      note_q       <= note_d;
`ifdef NOTE_SEQ_CHECKSUM_EN
      time_q       <= time_d;
`endif
      presc_q      <= presc_d;
      ms_q         <= ms_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      d_state_q    <= d_state_d;
      en_q         <= en_d;
      music_note_q <= music_note_d;
      music_time_q <= music_time_d;
    end
  end

  assign en         = en_q;
  assign music_note = music_note_q;
  assign music_time = music_time_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_note_sequencer.sv
// Testbench for uart_note_sequencer: directed scenario sequence with random
// note data, a behavioural queue model of the expected FIFO contents and a
// simple player model answering the en/music_busy handshake.
module tb_uart_note_sequencer;

   localparam int DEPTH      = 8;
   localparam int CLK_PER_MS = 10;
   localparam int TIMEOUT_MS = 20;

   logic                   clk_in = 1'b0;
   logic                   rst_n_in;
   logic [7:0]             rx_data;
   logic                   rx_valid;
   logic                   music_busy = 1'b0;
   logic                   en;
   logic [7:0]             music_note;
   logic [7:0]             music_time;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   frame_err;
   logic                   overflow;

   int checks = 0;
   int errors = 0;

   // player model controls: 0 = normal player, 1 = busy held high, 2 = ignores en
   int playerMode = 0;
   int playLen = 5;
   int playRemain = 0;
   logic [15:0] played[$];

   int frameErrCnt = 0;
   int overflowCnt = 0;
   int enRiseCnt = 0;
   logic enPrev = 1'b0;

   uart_note_sequencer #(
      .DEPTH      (DEPTH),
      .CLK_PER_MS (CLK_PER_MS),
      .TIMEOUT_MS (TIMEOUT_MS)
   ) dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .music_busy (music_busy),
      .en         (en),
      .music_note (music_note),
      .music_time (music_time),
      .fifo_level (fifo_level),
      .frame_err  (frame_err),
      .overflow   (overflow)
   );

   always #5 clk_in = ~clk_in;

   // Player model: accepts a request when idle, stays busy for playLen cycles and logs what it played
   always @(negedge clk_in) begin
      if (!rst_n_in) begin
         music_busy = 1'b0;
         playRemain = 0;
      end else if (playerMode == 1) begin
         music_busy = 1'b1;
         playRemain = 0;
      end else if (playerMode == 2) begin
         music_busy = 1'b0;
         playRemain = 0;
      end else if (playRemain > 0) begin
         playRemain = playRemain - 1;
         if (playRemain == 0) music_busy = 1'b0;
      end else if (en && !music_busy) begin
         music_busy = 1'b1;
         playRemain = playLen;
         played.push_back({music_note, music_time});
      end else begin
         music_busy = 1'b0;
      end
   end

   // Event monitor counting output pulses and en rising edges
   always @(negedge clk_in) begin
      if (frame_err === 1'b1) frameErrCnt = frameErrCnt + 1;
      if (overflow === 1'b1) overflowCnt = overflowCnt + 1;
      if (en === 1'b1 && enPrev !== 1'b1) enRiseCnt = enRiseCnt + 1;
      enPrev = en;
   end

   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // one UART byte: optional idle gap first, then a single-cycle rx_valid strobe
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] note, input logic [7:0] dur);
      applyStimulus(8'hA5, $urandom_range(0, 2));
      applyStimulus(note, $urandom_range(0, 2));
      applyStimulus(dur, $urandom_range(0, 2));
`ifdef NOTE_SEQ_CHECKSUM_EN
      applyStimulus(note ^ dur ^ 8'h5A, $urandom_range(0, 2));
`endif
   endtask

   task automatic sendGarbage(input int count);
      logic [7:0] g;
      for (int i = 0; i < count; i++) begin
         g = 8'($urandom_range(0, 255));
         if (g == 8'hA5) g = 8'h00;
         applyStimulus(g, $urandom_range(0, 1));
      end
   endtask

   initial begin
      logic [15:0] refQ[$];
      int expOvf;
      int base;
      int enBase;
      int errBase;
      int n;
      logic [7:0] nt;
      logic [7:0] dr;
      logic [15:0] firstNote;

      rst_n_in = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) tick();

      // reset values
      checkOutput("reset_en", en, 0);
      checkOutput("reset_note", music_note, 0);
      checkOutput("reset_time", music_time, 0);
      checkOutput("reset_level", fifo_level, 0);
      checkOutput("reset_frame_err", frame_err, 0);
      checkOutput("reset_overflow", overflow, 0);
      rst_n_in = 1'b1;
      repeat (2) tick();

      // single frame to an idle player
      playerMode = 0;
      playLen = 5;
      sendFrame(8'h3C, 8'h10);
      n = 0;
      while (en !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("single_en_rise", en, 1);
      checkOutput("single_note", music_note, 8'h3C);
      checkOutput("single_time", music_time, 8'h10);
      checkOutput("single_busy_seen", music_busy, 1);
      tick();
      checkOutput("single_en_fall", en, 0);
      repeat (20) tick();

      // fill the FIFO with busy held high; the ninth frame overflows
      playerMode = 1;
      tick();
      refQ.delete();
      expOvf = 0;
      base = overflowCnt;
      for (int k = 0; k < DEPTH + 1; k++) begin
         sendGarbage($urandom_range(0, 2));
         nt = 8'($urandom_range(0, 254));
         dr = 8'($urandom_range(0, 255));
         sendFrame(nt, dr);
         if (refQ.size() < DEPTH) refQ.push_back({nt, dr});
         else expOvf++;
         checkOutput($sformatf("fill_level_%0d", k), fifo_level, refQ.size());
      end
      tick();
      checkOutput("overflow_pulses", overflowCnt - base, expOvf);

      // release the player and drain in order
      base = played.size();
      playerMode = 0;
      n = 0;
      while (played.size() < base + refQ.size() && n < 3000) begin
         tick();
         n++;
      end
      checkOutput("drain_count", played.size() - base, refQ.size());
      for (int k = 0; k < refQ.size(); k++) begin
         if (base + k < played.size())
            checkOutput($sformatf("drain_entry_%0d", k), played[base + k], refQ[k]);
      end
      repeat (20) tick();
      checkOutput("drain_level", fifo_level, 0);

`ifdef NOTE_SEQ_CHECKSUM_EN
      // bad checksum
      errBase = frameErrCnt;
      enBase = enRiseCnt;
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h3C, 0);
      applyStimulus(8'h10, 0);
      applyStimulus(8'h00, 0);
      repeat (5) tick();
      checkOutput("badsum_err", frameErrCnt - errBase, 1);
      checkOutput("badsum_level", fifo_level, 0);
      checkOutput("badsum_no_en", enRiseCnt - enBase, 0);
`endif

      // inter-byte timeout, then a normal frame is accepted
      playerMode = 1;
      tick();
      errBase = frameErrCnt;
      applyStimulus(8'hA5, 1);
      applyStimulus(8'h3C, 0);
      n = 0;
      while (frame_err !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checkOutput("timeout_cycles", n, TIMEOUT_MS * CLK_PER_MS);
      tick();
      checkOutput("timeout_pulse_end", frame_err, 0);
      checkOutput("timeout_err_count", frameErrCnt - errBase, 1);
      sendFrame(8'h11, 8'h22);
      checkOutput("after_timeout_level", fifo_level, 1);
      base = played.size();
      playerMode = 0;
      n = 0;
      while (played.size() == base && n < 100) begin
         tick();
         n++;
      end
      if (played.size() > base) checkOutput("after_timeout_note", played[base], 16'h1122);
      else checkOutput("after_timeout_played", played.size() - base, 1);
      repeat (20) tick();

      // flush while the first of three notes plays
      playLen = 150;
      base = played.size();
      enBase = enRiseCnt;
      firstNote = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
      sendFrame(firstNote[15:8], firstNote[7:0]);
      sendFrame(8'($urandom_range(0, 254)), 8'($urandom_range(0, 255)));
      sendFrame(8'($urandom_range(0, 254)), 8'($urandom_range(0, 255)));
      checkOutput("flush_queued_level", fifo_level, 2);
      sendFrame(8'hFF, 8'($urandom_range(0, 255)));
      checkOutput("flush_level", fifo_level, 0);
      repeat (320) tick();
      checkOutput("flush_played_count", played.size() - base, 1);
      if (played.size() > base) checkOutput("flush_played_note", played[base], firstNote);
      checkOutput("flush_en_count", enRiseCnt - enBase, 1);
      checkOutput("flush_final_level", fifo_level, 0);

      // asynchronous reset while a request is pending
      playerMode = 2;
      tick();
      sendFrame(8'h42, 8'h24);
      n = 0;
      while (en !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checkOutput("req_en_before_reset", en, 1);
      #2;
      rst_n_in = 1'b0;
      #1;
      checkOutput("async_reset_en", en, 0);
      checkOutput("async_reset_level", fifo_level, 0);
      checkOutput("async_reset_note", music_note, 0);
      repeat (3) tick();
      rst_n_in = 1'b1;
      enBase = enRiseCnt;
      repeat (30) tick();
      checkOutput("post_reset_no_en", enRiseCnt - enBase, 0);
      checkOutput("post_reset_level", fifo_level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
